// File: rtl/mmc5_pkg.sv
// Shared definitions for the MMC5 PPU snoop and the mapper that consumes ppuflags.
// The mapper unpacks ppuflags with ppu_flags_t or the bit positions below.
package mmc5_pkg;

  localparam logic [8:0] LAST_DOT        = 9'd340;
  localparam logic [8:0] PRERENDER_LINE  = 9'd261;
  localparam logic [8:0] POSTRENDER_LINE = 9'd240;
  localparam logic [8:0] SCANLINE_PRE    = 9'h1FF;

  localparam int FLAG_IN_FRAME     = 0;
  localparam int FLAG_SPRITE16     = 1;
  localparam int FLAG_CYCLE_LSB    = 2;
  localparam int FLAG_CYCLE_MSB    = 10;
  localparam int FLAG_SCANLINE_LSB = 11;
  localparam int FLAG_SCANLINE_MSB = 19;

  typedef struct packed {
    logic [8:0] scanline;
    logic [8:0] cycle;
    logic       sprite16;
    logic       in_frame;
  } ppu_flags_t;

  function automatic ppu_flags_t unpack_flags(input logic [19:0] raw);
    return ppu_flags_t'(raw);
  endfunction

endpackage

// File: rtl/mmc5_nt_match.sv
// Detects three identical consecutive nametable fetches, which the PPU issues
// only at the end of each rendered scanline.
module mmc5_nt_match (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        chr_read,
  input  logic [13:0] chr_ain,
  output logic        detect
);

  logic [13:0] last_addr_q, last_addr_d;
  logic [1:0]  match_cnt_q, match_cnt_d;
  logic        is_nt;

  assign is_nt = (chr_ain[13:12] == 2'b10);

  // match_cnt counts repeats after the first fetch of an address, so the
  // third identical fetch arrives with one repeat already recorded.
  always_comb begin
    last_addr_d = last_addr_q;
    match_cnt_d = match_cnt_q;
    detect      = 1'b0;
    if (ce && chr_read) begin
      if (is_nt && (chr_ain == last_addr_q)) begin
        if (match_cnt_q == 2'd1) begin
          detect      = 1'b1;
          match_cnt_d = 2'd0;
        end else begin
          match_cnt_d = match_cnt_q + 2'd1;
        end
      end else begin
        last_addr_d = chr_ain;
        match_cnt_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_addr_q <= '0;
      match_cnt_q <= '0;
    end else begin
      last_addr_q <= last_addr_d;
      match_cnt_q <= match_cnt_d;
    end
  end

endmodule

// File: rtl/mmc5_ppu_snoop.sv
// Reconstructs PPU scanline/dot timing from CHR-bus reads and CPU writes to
// $2000/$2001, producing the packed ppuflags vector for the MMC5 mapper.
module mmc5_ppu_snoop
  import mmc5_pkg::*;
#(
  parameter int IDLE_DOTS  = 4,
  parameter int DETECT_DOT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [13:0] chr_ain,
  input  logic        chr_read,
  input  logic [15:0] prg_ain,
  input  logic        prg_write,
  input  logic [7:0]  prg_din,
  output logic [19:0] ppuflags,
  output logic        scanline_tick
);

  localparam int              IW       = $clog2(IDLE_DOTS + 1);
  localparam logic [IW-1:0]   IDLE_MAX = IW'(IDLE_DOTS);
  localparam logic [8:0]      DET_DOT  = 9'(DETECT_DOT);

  logic          in_frame_q, in_frame_d;
  logic          sprite16_q, sprite16_d;
  logic [8:0]    cycle_q, cycle_d;
  logic [8:0]    scanline_q, scanline_d;
  logic          tick_q, tick_d;
  logic [IW-1:0] idle_q, idle_d;

  logic       detect;
  logic       reg_wr;
  logic       ctrl_wr;
  logic       render_off_wr;
  logic       wrap;
  logic       timeout;
  ppu_flags_t flags;
  logic       unused_bits;

  mmc5_nt_match u_nt_match (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .chr_read (chr_read),
    .chr_ain  (chr_ain),
    .detect   (detect)
  );

  assign reg_wr        = ce && prg_write && (prg_ain[15:13] == 3'b001);
  assign ctrl_wr       = reg_wr && (prg_ain[2:0] == 3'd0);
  assign render_off_wr = reg_wr && (prg_ain[2:0] == 3'd1) && (prg_din[4:3] == 2'b00);
  assign unused_bits   = ^{prg_ain[12:3], prg_din[7:6], prg_din[2:0]};

  // Priority: rendering-off write > detect > idle timeout > dot-340 wrap.
  always_comb begin
    in_frame_d = in_frame_q;
    sprite16_d = sprite16_q;
    cycle_d    = cycle_q;
    scanline_d = scanline_q;
    tick_d     = 1'b0;
    idle_d     = idle_q;
    wrap       = 1'b0;
    timeout    = 1'b0;

    if (ce) begin
      if (chr_read) begin
        idle_d = '0;
      end else if (idle_q != IDLE_MAX) begin
        idle_d = idle_q + 1'b1;
      end
      timeout = !chr_read && (idle_d == IDLE_MAX) && in_frame_q;

      if (detect) begin
        cycle_d = DET_DOT;
      end else if (cycle_q == LAST_DOT) begin
        cycle_d = 9'd0;
        wrap    = 1'b1;
      end else begin
        cycle_d = cycle_q + 9'd1;
      end

      if (detect) begin
        tick_d = 1'b1;
        if (!in_frame_q) begin
          in_frame_d = 1'b1;
          scanline_d = 9'd0;
        end else begin
          scanline_d = scanline_q + 9'd1;
        end
      end else if (timeout) begin
        in_frame_d = 1'b0;
        scanline_d = POSTRENDER_LINE;
      end else if (wrap && !in_frame_q) begin
        // Bit 8 of the pre-render value flags that line to the mapper.
        if (scanline_q == PRERENDER_LINE) begin
          scanline_d = SCANLINE_PRE;
        end else if ((scanline_q >= POSTRENDER_LINE) && (scanline_q < PRERENDER_LINE)) begin
          scanline_d = scanline_q + 9'd1;
        end
      end

      if (render_off_wr) begin
        in_frame_d = 1'b0;
        scanline_d = POSTRENDER_LINE;
        tick_d     = 1'b0;
      end
      if (ctrl_wr) begin
        sprite16_d = prg_din[5];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_frame_q <= 1'b0;
      sprite16_q <= 1'b0;
      cycle_q    <= '0;
      scanline_q <= '0;
      tick_q     <= 1'b0;
      idle_q     <= '0;
    end else begin
      in_frame_q <= in_frame_d;
      sprite16_q <= sprite16_d;
      cycle_q    <= cycle_d;
      scanline_q <= scanline_d;
      tick_q     <= tick_d;
      idle_q     <= idle_d;
    end
  end

  always_comb begin
    flags          = '0;
    flags.scanline = scanline_q;
    flags.cycle    = cycle_q;
    flags.sprite16 = sprite16_q;
    flags.in_frame = in_frame_q;
  end

  assign ppuflags      = flags;
  assign scanline_tick = tick_q;

endmodule

// File: tb/tb_mmc5_ppu_snoop.sv
// Directed bench for mmc5_ppu_snoop: every clk is one PPU dot unless ce is
// dropped; expected flags are hand-derived from the read/write sequence.
module tb_mmc5_ppu_snoop;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [13:0] chr_ain;
  logic        chr_read;
  logic [15:0] prg_ain;
  logic        prg_write;
  logic [7:0]  prg_din;
  logic [19:0] ppuflags;
  logic        scanline_tick;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  mmc5_ppu_snoop dut (
    .clk           (clk),
    .reset         (reset),
    .ce            (ce),
    .chr_ain       (chr_ain),
    .chr_read      (chr_read),
    .prg_ain       (prg_ain),
    .prg_write     (prg_write),
    .prg_din       (prg_din),
    .ppuflags      (ppuflags),
    .scanline_tick (scanline_tick)
  );

  function automatic logic [19:0] flags(input logic [8:0] sl, input logic [8:0] cy,
                                        input logic s16, input logic inf);
    return {sl, cy, s16, inf};
  endfunction

  task automatic checkOutput(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // One dot: drive the buses, let the edge happen, sample 1 time unit later.
  task automatic applyStimulus(input logic rd, input logic [13:0] a, input logic wr,
                               input logic [15:0] pa, input logic [7:0] pd);
    chr_read  = rd;
    chr_ain   = a;
    prg_write = wr;
    prg_ain   = pa;
    prg_din   = pd;
    @(posedge clk);
    #1;
    chr_read  = 1'b0;
    prg_write = 1'b0;
  endtask

  task automatic readDot(input logic [13:0] a);
    applyStimulus(1'b1, a, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic idleDots(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 14'h0000, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic ntTriple(input logic [13:0] a);
    readDot(a);
    readDot(a);
    readDot(a);
  endtask

  task automatic filler();
    readDot(14'h0000);
    idleDots(1);
    readDot(14'h0000);
    idleDots(1);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; chr_ain = '0; chr_read = 1'b0;
    prg_ain = '0; prg_write = 1'b0; prg_din = '0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset_flags", ppuflags, 20'h0);
    checkOutput("reset_tick", {19'b0, scanline_tick}, 20'h0);
    reset = 1'b0;

    // first triple out of frame
    readDot(14'h2400);
    checkOutput("triple_r1_tick", {19'b0, scanline_tick}, 20'h0);
    readDot(14'h2400);
    checkOutput("triple_r2_tick", {19'b0, scanline_tick}, 20'h0);
    readDot(14'h2400);
    checkOutput("triple_flags", ppuflags, flags(9'd0, 9'd2, 1'b0, 1'b1));
    checkOutput("triple_tick", {19'b0, scanline_tick}, 20'h1);

    ce = 1'b0;
    readDot(14'h2400);
    checkOutput("ce0_flags", ppuflags, flags(9'd0, 9'd2, 1'b0, 1'b1));
    checkOutput("ce0_tick", {19'b0, scanline_tick}, 20'h0);
    ce = 1'b1;
    filler();

    // full rendered frame
    for (int line = 1; line < 240; line++) begin
      ntTriple(14'h2000 + 14'(line));
      checkOutput($sformatf("frame_line%0d", line), ppuflags, flags(9'(line), 9'd2, 1'b0, 1'b1));
      checkOutput($sformatf("frame_tick%0d", line), {19'b0, scanline_tick}, 20'h1);
      if (line < 239) filler();
    end
    idleDots(3);
    checkOutput("idle3_still_in", ppuflags, flags(9'd239, 9'd5, 1'b0, 1'b1));
    idleDots(1);
    checkOutput("idle4_drop", ppuflags, flags(9'd240, 9'd6, 1'b0, 1'b0));
    idleDots(334);
    checkOutput("dot340", ppuflags, flags(9'd240, 9'd340, 1'b0, 1'b0));
    idleDots(1);
    checkOutput("wrap241", ppuflags, flags(9'd241, 9'd0, 1'b0, 1'b0));
    for (int s = 242; s <= 260; s++) begin
      idleDots(341);
      checkOutput($sformatf("vblank%0d", s), ppuflags, flags(9'(s), 9'd0, 1'b0, 1'b0));
    end
    idleDots(341);
    checkOutput("prerender261", ppuflags, flags(9'd261, 9'd0, 1'b0, 1'b0));
    idleDots(341);
    checkOutput("prerender1ff", ppuflags, flags(9'h1FF, 9'd0, 1'b0, 1'b0));
    idleDots(341);
    checkOutput("prerender_hold", ppuflags, flags(9'h1FF, 9'd0, 1'b0, 1'b0));

    // $2400,$2400,$2401,$2401,$2401 -> detect only on the fifth read
    readDot(14'h2400);
    checkOutput("pat_r1", {19'b0, scanline_tick}, 20'h0);
    readDot(14'h2400);
    checkOutput("pat_r2", {19'b0, scanline_tick}, 20'h0);
    readDot(14'h2401);
    checkOutput("pat_r3", {19'b0, scanline_tick}, 20'h0);
    readDot(14'h2401);
    checkOutput("pat_r4", {19'b0, scanline_tick}, 20'h0);
    readDot(14'h2401);
    checkOutput("pat_r5_tick", {19'b0, scanline_tick}, 20'h1);
    checkOutput("pat_r5_flags", ppuflags, flags(9'd0, 9'd2, 1'b0, 1'b1));
    for (int i = 0; i < 5; i++) begin
      readDot(14'h0400);
      checkOutput($sformatf("pt_read%0d", i), {19'b0, scanline_tick}, 20'h0);
    end
    checkOutput("pt_flags", ppuflags, flags(9'd0, 9'd7, 1'b0, 1'b1));

    // sprite size via $2000 and its $2008 mirror
    applyStimulus(1'b0, 14'h0000, 1'b1, 16'h2000, 8'h20);
    checkOutput("ctrl_s16_on", ppuflags, flags(9'd0, 9'd8, 1'b1, 1'b1));
    applyStimulus(1'b0, 14'h0000, 1'b1, 16'h2008, 8'h00);
    checkOutput("ctrl_mirror_off", ppuflags, flags(9'd0, 9'd9, 1'b0, 1'b1));
    readDot(14'h0000);

    // rendering-off write on the same dot as a detect at scanline 100
    for (int line = 1; line <= 100; line++) begin
      ntTriple(14'h2000 + 14'(line));
      filler();
    end
    checkOutput("line100", ppuflags, flags(9'd100, 9'd6, 1'b0, 1'b1));
    readDot(14'h2200);
    readDot(14'h2200);
    applyStimulus(1'b1, 14'h2200, 1'b1, 16'h2001, 8'h00);
    checkOutput("off_vs_detect_flags", ppuflags, flags(9'd240, 9'd2, 1'b0, 1'b0));
    checkOutput("off_vs_detect_tick", {19'b0, scanline_tick}, 20'h0);

    // asynchronous reset mid-frame at scanline 57, cycle 200
    ntTriple(14'h2400);
    checkOutput("reenter_frame", ppuflags, flags(9'd0, 9'd2, 1'b0, 1'b1));
    filler();
    for (int line = 1; line <= 57; line++) begin
      ntTriple(14'h2000 + 14'(line));
      if (line < 57) filler();
    end
    for (int i = 0; i < 198; i++) readDot(14'h0000);
    checkOutput("pre_reset", ppuflags, flags(9'd57, 9'd200, 1'b0, 1'b1));
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_flags", ppuflags, 20'h0);
    checkOutput("async_reset_tick", {19'b0, scanline_tick}, 20'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    ntTriple(14'h2400);
    checkOutput("post_reset_flags", ppuflags, flags(9'd0, 9'd2, 1'b0, 1'b1));
    checkOutput("post_reset_tick", {19'b0, scanline_tick}, 20'h1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
